// File: rtl/wb_stage_ctrl.sv
// Write-back stage: owns the M/W pipeline register, decodes register-file write
// controls, and holds loads until memory data arrives or a watchdog expires.
module wb_stage_ctrl #(
  parameter int DATA_W       = 32,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              valid_in,
  input  logic              change_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] pc8_in,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ready_out,
  output logic              regwrite,
  output logic [4:0]        waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [1:0]        wdctr,
  output logic              busy,
  output logic              timeout_err
);

  localparam int               CNT_W    = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;

  localparam logic [5:0] FN_ROTRV  = 6'h06;
  localparam logic [5:0] FN_MOVZ   = 6'h0A;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_SLT    = 6'h2A;

  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_LINK = 2'b10;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

  state_t           state;
  logic [31:0]      instr_q;
  logic             change_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] pc8_q;
  logic [CNT_W-1:0] cnt;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

  // Pick the addressed half/byte out of the aligned word and extend it.
  function automatic logic [DATA_W-1:0] load_ext(input logic [31:0] word,
                                                 input logic [1:0]  ofs,
                                                 input logic [5:0]  op);
    logic [15:0]       half_v;
    logic [7:0]        byte_v;
    logic [DATA_W-1:0] res;
    half_v = ofs[1] ? word[31:16] : word[15:0];
    byte_v = word[{ofs, 3'b000} +: 8];
    res    = '0;
    case (op)
      OP_LH:   res = {{(DATA_W-16){half_v[15]}}, half_v};
      OP_LB:   res = {{(DATA_W-8){byte_v[7]}}, byte_v};
      default: res[31:0] = word;
    endcase
    return res;
  endfunction

  logic [5:0] op, funct;
  logic [4:0] rt, rd, sa;
  logic       is_rtype, is_movz, is_bgezal, is_jal, is_link, is_load, known, qual;
  logic       capture, timeout;
  logic       unused_rs;

  assign op    = instr_q[31:26];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign sa    = instr_q[10:6];
  assign funct = instr_q[5:0];
  // rs is consumed upstream; the write-back stage never needs it.
  assign unused_rs = ^instr_q[25:21];

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    is_rtype  = (op == OP_RTYPE);
    is_movz   = is_rtype && (funct == FN_MOVZ);
    is_bgezal = (op == OP_REGIMM) && (rt == RT_BGEZAL);
    is_jal    = (op == OP_JAL);
    is_link   = is_jal || is_bgezal;
    is_load   = is_load_op(op);
    known     = is_link || is_load
             || (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI)
             || (is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) ||
                              (funct == FN_OR)   || (funct == FN_SLT)  ||
                              (funct == FN_MOVZ) ||
                              ((funct == FN_ROTRV) && (sa == 5'd1))));

    waddr = rt;
    if (is_link)       waddr = 5'd31;
    else if (is_rtype) waddr = rd;

    wdctr = WD_ALU;
    if (is_load)      wdctr = WD_MEM;
    else if (is_link) wdctr = WD_LINK;

    qual = known && !((is_bgezal || is_movz) && change_q) && (waddr != 5'd0);
  end

  assign busy      = (state == WAIT);
  assign ready_out = (state != WAIT) || mem_rvalid;
  assign capture   = valid_in && ready_out;
  assign timeout   = (state == WAIT) && !mem_rvalid && (cnt == CNT_LAST);

  assign regwrite  = qual && ((state == EXEC) || ((state == WAIT) && mem_rvalid));
  assign wdata     = (state == WAIT) ? load_ext(mem_rdata[31:0], alu_q[1:0], op)
                   : (is_link ? pc8_q : alu_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      instr_q     <= '0;
      change_q    <= 1'b0;
      alu_q       <= '0;
      pc8_q       <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (capture) begin
        instr_q  <= instr_in;
        change_q <= change_in;
        alu_q    <= alu_in;
        pc8_q    <= pc8_in;
        cnt      <= '0;
        state    <= is_load_op(instr_in[31:26]) ? WAIT : EXEC;
      end else begin
        case (state)
          EXEC:    state <= IDLE;
          WAIT: begin
            if (mem_rvalid || timeout) state <= IDLE;
            else                       cnt   <= cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
      if (timeout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/wb_stage_ctrl.md
# wb_stage_ctrl

Parametrised write-back stage for the five-stage MIPS pipeline, the successor to the current combinational W-stage decoder. It owns the M/W pipeline register, decodes the held instruction into register-file write controls, and selects and sign- or zero-extends write data. It also tolerates a variable-latency data memory by holding loads until read data arrives, with a watchdog timeout. It sits between the memory stage and the register file; `ready_out` back-pressures the memory stage.

## Interface
- `DATA_W`, 32: datapath width; must be ≥ 32.
- `LOAD_TIMEOUT`, 15: maximum cycles a load waits for `mem_rvalid`; must be ≥ 1.
- `clk`  input  1  rising-edge clock; single clock domain.
- `reset`  input  1  asynchronous, active-low reset.
- `instr_in`  input  32  instruction leaving M stage.
- `valid_in`  input  1  `instr_in` and companions are valid.
- `change_in`  input  1  condition flag; suppresses the write for `bgezal` and `movz` when 1.
- `alu_in`  input  DATA_W  ALU result; `[1:0]` is the load byte address.
- `pc8_in`  input  DATA_W  PC+8 link value.
- `mem_rvalid`  input  1  load data valid.
- `mem_rdata`  input  DATA_W  aligned memory word.
- `ready_out`  output  1  stage accepts `valid_in` this cycle.
- `regwrite`  output  1  register-file write enable.
- `waddr`  output  5  destination register.
- `wdata`  output  DATA_W  write data.
- `wdctr`  output  2  source: 00 ALU, 01 memory, 10 link.
- `busy`  output  1  load pending (state WAIT).
- `timeout_err`  output  1  sticky load-timeout flag.

## Operation
- States: IDLE (W register empty), EXEC (non-load held), WAIT (load held).
- Capture occurs on `valid_in && ready_out`. The capture latches `instr_in`, `change_in`, `alu_in` and `pc8_in`. Next state is WAIT for `lw`, `lh` or `lb`; otherwise EXEC.
- If there is no capture, next state is IDLE from EXEC, and IDLE from WAIT once `mem_rvalid` is seen or a timeout occurs.
- `ready_out` is 1 in IDLE and EXEC. In WAIT it equals `mem_rvalid`, so back-to-back issue is allowed on the completing cycle.
- Decode uses the held instruction: op = [31:26], funct = [5:0], rt = [20:16], rd = [15:11], sa = [10:6].
  - R-type (op 0): `addu` 21h, `subu` 23h, `or` 25h, `slt` 2Ah, `movz` 0Ah, `rotrv` 06h with sa = 1.
  - I-type: `addiu` 09h, `ori` 0Dh, `lui` 0Fh, `lw` 23h, `lh` 21h, `lb` 20h.
  - `jal` is op 03h; `bgezal` is op 01h with rt = 11h.
- `waddr`:
  - 31 for `jal` and `bgezal`.
  - rd for R-type.
  - rt otherwise.
- `wdctr` is 01 for loads, 10 for `jal` and `bgezal`, and 00 otherwise.
- Write qualification: the held instruction must be in the list above. `bgezal` and `movz` additionally need latched change = 0. Writes with `waddr` = 0 are always suppressed (`regwrite` = 0).
- EXEC: `regwrite` is the qualified decode for one cycle. `wdata` is the held ALU value, or the held PC+8 for link instructions.
- WAIT: `regwrite` = 1 only in the cycle `mem_rvalid` = 1, with `wdata` = extended `mem_rdata`.
  - `lw`: the full word.
  - `lh`: sign-extends half `alu[1]` (0 = [15:0], 1 = [31:16]).
  - `lb`: sign-extends byte `alu[1:0]` (lane n = [8n+7:8n]).
  - Bits above 31 are sign-filled for `lh`/`lb` and zero-filled for `lw` when DATA_W > 32.
- Timeout counter:
  - Cleared on entry to WAIT; increments each WAIT cycle without `mem_rvalid`.
  - When the counter equals LOAD_TIMEOUT − 1 with `mem_rvalid` = 0, the load is dropped with no write. `timeout_err` is set and the state returns to IDLE.
  - `ready_out` stays 0 in that timeout cycle.
  - Width is ceil(log2(LOAD_TIMEOUT + 1)).
- `timeout_err` is cleared only by reset.

## Timing
- Reset (asynchronous, `reset` = 0): state IDLE, W register = 0, counter = 0, `timeout_err` = 0. Outputs during reset: `regwrite` 0, `waddr` 0, `wdata` 0, `wdctr` 00, `busy` 0, `ready_out` 1.
- Reset asserted mid-WAIT abandons the load with no write. A `mem_rvalid` arriving after reset is ignored in IDLE.
- Latency:
  - Non-load: write one cycle after capture.
  - Load: write in the first cycle of WAIT with `mem_rvalid` = 1, which is earliest one cycle after capture.
- All outputs except `ready_out` and the WAIT-cycle `regwrite`/`wdata` are registered-state-derived. `ready_out`, `regwrite` and `wdata` in WAIT depend combinationally on `mem_rvalid`/`mem_rdata`.
- `mem_rvalid` outside WAIT is ignored.

## Test plan
- `addu` $3 (instr 00221821h), alu_in = 5, `valid_in` for 1 cycle -> next cycle `regwrite` 1, `waddr` 3, `wdata` 5, `wdctr` 00; the cycle after, IDLE with `regwrite` 0.
- `lb` (instr 80A40000h, rt = 4), alu_in[1:0] = 2, `mem_rvalid` after 3 cycles with rdata 0080FF00h -> `busy` 1 for 3 cycles, `ready_out` 0; then `regwrite` 1, `waddr` 4, `wdata` FFFFFF80h, `wdctr` 01.
- `jal` (0C000010h), pc8 = 00003008h -> `waddr` 31, `wdata` 00003008h, `wdctr` 10. `bgezal` with change = 1 -> `regwrite` 0.
- `ori` into $0 -> `regwrite` 0. `movz` with change = 1 -> `regwrite` 0; with change = 0 -> `regwrite` 1.
- `lw`, `mem_rvalid` held 0, LOAD_TIMEOUT = 15 -> 15 WAIT cycles, no write, `timeout_err` 1 in the cycle after the 15th, IDLE, `ready_out` 1. A later `mem_rvalid` pulse produces no write.
- `lw` completing with `valid_in` high on the same cycle -> write and capture in one cycle; the next instruction writes on the following cycle. Reset pulse during WAIT -> all outputs return to reset values immediately, with no write.
